msg_tx_serializer: RTL

MSG_TX_SERIALIZER -- requirements
Module: msg_tx_serializer

---
 rtl/msg_tx_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/msg_tx_serializer.sv
// ============================================================================
// msg_tx_serializer
//
// Feeds a multi-byte message to a byte-wide UART transmitter, one byte at a
// time. Zero bytes can optionally be dropped, the byte order is selectable,
// and an optional terminator byte is sent after the message.
//
// Parameters
//   NUM_BYTES  message length in bytes (1..16)
//   SKIP_ZERO  1: bytes equal to 8'h00 are not transmitted
//   MSB_FIRST  0: byte 0 goes first, 1: byte NUM_BYTES-1 goes first
//   TERM_EN    1: TERM_BYTE is appended after the message
//   TERM_BYTE  terminator value
//
// Ports
//   clock           single clock, rising edge
//   reset           asynchronous, active-high reset
//   msg_in          packed message, byte k at [8k+7:8k]
//   start_transmit  request to send msg_in (only honoured in IDLE)
//   abort           synchronous cancel of the message in progress
//   tx_done         UART pulse: current byte finished
//   tx_byte         byte offered to the UART (holds between sends)
//   send            one-cycle strobe launching tx_byte
//   busy            high whenever the FSM is not in IDLE
//   done            one-cycle pulse on normal completion
//   sent_count      bytes launched for current/last message, incl. terminator
// ============================================================================
module msg_tx_serializer #(
    parameter int         NUM_BYTES = 7,
    parameter bit         SKIP_ZERO = 1'b1,
    parameter bit         MSB_FIRST = 1'b0,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_BYTE = 8'h0A
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BYTES*8-1:0] msg_in,
    input  logic                   start_transmit,
    input  logic                   abort,
    input  logic                   tx_done,
    output logic [7:0]             tx_byte,
    output logic                   send,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             sent_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT,
        TERM_WAIT
    } state_t;

    localparam logic [4:0] MSG_LEN = 5'(NUM_BYTES);

    state_t                   state_reg;
    logic [NUM_BYTES*8-1:0]   msg_reg;
    logic [4:0]               idx_reg;    // count of bytes already examined

    // Latched message viewed as individual bytes.
    logic [7:0] msg_bytes [NUM_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
            assign msg_bytes[gi] = msg_reg[8*gi +: 8];
        end
    endgenerate

    logic       all_scanned;
    logic [4:0] byte_pos;
    logic [7:0] cur_byte;
    logic       skip_byte;

    // Byte currently under examination. Once every byte has been examined
    // byte_pos falls outside the message (wraps for MSB_FIRST) and cur_byte
    // reads 0; it is not used in that case.
    always_comb begin
        all_scanned = (idx_reg == MSG_LEN);
        byte_pos    = MSB_FIRST ? (MSG_LEN - 5'd1 - idx_reg) : idx_reg;
        cur_byte    = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_pos == 5'(i)) begin
                cur_byte = msg_bytes[i];
            end
        end
        skip_byte = SKIP_ZERO && (cur_byte == 8'h00);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            msg_reg    <= '0;
            idx_reg    <= '0;
            tx_byte    <= 8'h00;
            send       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= 5'd0;
        end else begin
            // Strobes last a single cycle unless re-asserted below.
            send <= 1'b0;
            done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start_transmit) begin
                        msg_reg    <= msg_in;
                        idx_reg    <= 5'd0;
                        sent_count <= 5'd0;
                        busy       <= 1'b1;
                        state_reg  <= SCAN;
                    end
                end

                SCAN: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (all_scanned) begin
                        if (TERM_EN) begin
                            tx_byte    <= TERM_BYTE;
                            send       <= 1'b1;
                            sent_count <= sent_count + 5'd1;
                            state_reg  <= TERM_WAIT;
                        end else begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (skip_byte) begin
                        idx_reg <= idx_reg + 5'd1;
                    end else begin
                        tx_byte    <= cur_byte;
                        send       <= 1'b1;
                        sent_count <= sent_count + 5'd1;
                        idx_reg    <= idx_reg + 5'd1;
                        state_reg  <= WAIT;
                    end
                end

                // While send is high we are in the launch cycle; a tx_done
                // seen then belongs to the previous byte and is ignored.
                WAIT: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (tx_done && !send) begin
                        state_reg <= SCAN;
                    end
                end

                TERM_WAIT: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (tx_done && !send) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
